// File: rtl/vram_fetch_pkg.sv
// Shared lane-order type and width helpers for the VRAM video fetch sequencer.
package vram_fetch_pkg;

  typedef enum logic {
    LO_FIRST = 1'b0,
    HI_FIRST = 1'b1
  } lane_order_e;

  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int amt_w(input int shift_max);
    return (shift_max > 0) ? $clog2(shift_max + 1) : 1;
  endfunction

  function automatic int clamp_amt(input int amt, input int shift_max);
    return (amt > shift_max) ? shift_max : amt;
  endfunction

endpackage

// File: rtl/byte_delay_line.sv
// Push-enabled byte shift register; tap k returns the byte pushed k pushes ago
// (tap 0 returns zero, taps beyond SHIFT_MAX read the deepest entry).
module byte_delay_line
  import vram_fetch_pkg::*;
#(
  parameter int SHIFT_MAX = 3,
  parameter int BYTE_W    = 8,
  localparam int AMT_W    = amt_w(SHIFT_MAX)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic [AMT_W-1:0]  tap,
  output logic [BYTE_W-1:0] tap_byte
);

  logic [BYTE_W-1:0] dl_q [SHIFT_MAX];
  logic [BYTE_W-1:0] dl_d [SHIFT_MAX];
  int                k_sel;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dl_q <= '{default: '0};
    end else begin
      dl_q <= dl_d;
    end
  end

  always_comb begin
    dl_d = dl_q;
    if (push) begin
      dl_d[0] = din;
      for (int i = 1; i < SHIFT_MAX; i++) begin
        dl_d[i] = dl_q[i-1];
      end
    end
  end

  always_comb begin
    k_sel    = clamp_amt(int'(tap), SHIFT_MAX);
    tap_byte = '0;
    for (int i = 0; i < SHIFT_MAX; i++) begin
      if (k_sel == i + 1) begin
        tap_byte = dl_q[i];
      end
    end
  end

endmodule

// File: rtl/vram_fetch_seq.sv
// Video-side VRAM fetch sequencer: serialises each VRAM word into byte lanes, one per
// CAS strobe inside a video slot, with an optional byte delay for picture centring.
module vram_fetch_seq
  import vram_fetch_pkg::lane_order_e, vram_fetch_pkg::lane_w, vram_fetch_pkg::amt_w,
         vram_fetch_pkg::clamp_amt;
#(
  parameter int WORD_W    = 16,
  parameter int BYTE_W    = 8,
  parameter int SHIFT_MAX = 3,
  parameter int HI_FIRST  = 0,
  localparam int LANES    = WORD_W / BYTE_W,
  localparam int LANE_W   = lane_w(LANES),
  localparam int AMT_W    = amt_w(SHIFT_MAX)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_n,
  input  logic              ras_n,
  input  logic              cas_n,
  input  logic              de,
  input  logic              shift_en,
  input  logic [AMT_W-1:0]  shift_amt,
  input  logic [WORD_W-1:0] vram_din,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_strobe,
  output logic [LANE_W-1:0] lane_idx,
  output logic              overrun
);

  localparam lane_order_e LANE_ORDER =
    (HI_FIRST != 0) ? vram_fetch_pkg::HI_FIRST : vram_fetch_pkg::LO_FIRST;
  // Lane states are count-encoded: 0..LANES-1 are the lanes, LANES is DONE.
  localparam logic [LANE_W:0] DONE = (LANE_W + 1)'(LANES);

  logic [LANE_W:0]   state_q, state_d;
  logic              cas_n_q, cas_n_d;
  logic [BYTE_W-1:0] byte_out_q, byte_out_d;
  logic              strobe_q, strobe_d;
  logic              overrun_q, overrun_d;

  logic              cas_rise, active, push, in_done;
  logic [LANE_W-1:0] lane_cur, lane_phys;
  logic [BYTE_W-1:0] sel_byte, tap_byte, push_byte;
  logic [AMT_W-1:0]  k_amt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!cpu_n) begin
      state_d = '0;
    end else if (cas_rise && !in_done) begin
      state_d = state_q + (LANE_W + 1)'(1);
    end
  end

  always_comb begin
    lane_cur = '0;
    if (cpu_n) begin
      lane_cur = in_done ? LANE_W'(LANES - 1) : state_q[LANE_W-1:0];
    end
  end

  always_comb begin
    in_done   = (state_q == DONE);
    cas_rise  = !ras_n && !cas_n_q && cas_n;
    active    = !ras_n && !cas_n;
    push      = cas_rise && cpu_n && !in_done;
    k_amt     = shift_en ? AMT_W'(clamp_amt(int'(shift_amt), SHIFT_MAX)) : '0;
    lane_phys = (LANE_ORDER == vram_fetch_pkg::HI_FIRST) ? LANE_W'(LANES - 1) - lane_cur
                                                         : lane_cur;
    sel_byte  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_phys == LANE_W'(i)) begin
        sel_byte = vram_din[i*BYTE_W +: BYTE_W];
      end
    end
    push_byte = de ? sel_byte : '0;
  end

  // With no delay the lane byte goes straight out and display enable does not mask it.
  always_comb begin
    cas_n_d    = cas_n;
    strobe_d   = push;
    overrun_d  = overrun_q || (cas_rise && cpu_n && in_done);
    byte_out_d = byte_out_q;
    if (active && cpu_n) begin
      byte_out_d = (k_amt == '0) ? sel_byte : tap_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cas_n_q    <= 1'b1;
      byte_out_q <= '0;
      strobe_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cas_n_q    <= cas_n_d;
      byte_out_q <= byte_out_d;
      strobe_q   <= strobe_d;
      overrun_q  <= overrun_d;
    end
  end

  byte_delay_line #(
    .SHIFT_MAX (SHIFT_MAX),
    .BYTE_W    (BYTE_W)
  ) u_delay_line (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .din      (push_byte),
    .tap      (k_amt),
    .tap_byte (tap_byte)
  );

  assign byte_out    = byte_out_q;
  assign byte_strobe = strobe_q && cpu_n;
  assign lane_idx    = lane_cur;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_vram_fetch_seq.sv
// Scoreboard bench for vram_fetch_seq: a 16-bit LSB-first instance and a 32-bit
// MSB-first instance with a shallower delay line, checked against a byte-stream model.
module tb_vram_fetch_seq;

  typedef struct {
    logic [7:0] b;
    int         lane;
    logic       ovr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n   [2];
  logic       cpu_n     [2];
  logic       ras_n     [2];
  logic       cas_n     [2];
  logic       de        [2];
  logic       shift_en  [2];
  logic [1:0] shift_amt [2];
  logic [15:0] din0;
  logic [31:0] din1;

  logic [7:0] bo0, bo1;
  logic       bs0, bs1;
  logic       lane0;
  logic [1:0] lane1;
  logic       ov0, ov1;

  int lanes_p [2] = '{2, 4};
  int smax_p  [2] = '{3, 2};
  int hi_p    [2] = '{0, 1};

  // Reference model: every byte ever pushed into the delay stream, plus sticky overrun.
  logic [7:0] stream [2][1024];
  int         npush  [2];
  logic       ovr_m  [2];
  exp_t       q0[$];
  exp_t       q1[$];

  int checks   = 0;
  int failures = 0;

  vram_fetch_seq #(.WORD_W(16), .BYTE_W(8), .SHIFT_MAX(3), .HI_FIRST(0)) dut0 (
    .clk(clk), .reset_n(reset_n[0]), .cpu_n(cpu_n[0]), .ras_n(ras_n[0]),
    .cas_n(cas_n[0]), .de(de[0]), .shift_en(shift_en[0]), .shift_amt(shift_amt[0]),
    .vram_din(din0), .byte_out(bo0), .byte_strobe(bs0), .lane_idx(lane0), .overrun(ov0)
  );

  vram_fetch_seq #(.WORD_W(32), .BYTE_W(8), .SHIFT_MAX(2), .HI_FIRST(1)) dut1 (
    .clk(clk), .reset_n(reset_n[1]), .cpu_n(cpu_n[1]), .ras_n(ras_n[1]),
    .cas_n(cas_n[1]), .de(de[1]), .shift_en(shift_en[1]), .shift_amt(shift_amt[1]),
    .vram_din(din1), .byte_out(bo1), .byte_strobe(bs1), .lane_idx(lane1), .overrun(ov1)
  );

  function automatic logic [31:0] rdByte(input int inst);
    return (inst == 0) ? 32'(bo0) : 32'(bo1);
  endfunction

  function automatic logic [31:0] rdStrobe(input int inst);
    return (inst == 0) ? 32'(bs0) : 32'(bs1);
  endfunction

  function automatic logic [31:0] rdLane(input int inst);
    return (inst == 0) ? 32'(lane0) : 32'(lane1);
  endfunction

  function automatic logic [31:0] rdOvr(input int inst);
    return (inst == 0) ? 32'(ov0) : 32'(ov1);
  endfunction

  function automatic logic [7:0] laneByte(input int inst, input logic [31:0] word,
                                          input int lane);
    int          phys;
    logic [31:0] t;
    phys = (hi_p[inst] != 0) ? lanes_p[inst] - 1 - lane : lane;
    t    = word >> (8 * phys);
    return t[7:0];
  endfunction

  function automatic logic [7:0] pastByte(input int inst, input int k);
    return (npush[inst] >= k) ? stream[inst][npush[inst] - k] : 8'h00;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, actual, expected);
    end
  endtask

  task automatic monCheck(input int inst);
    exp_t e;
    int   qs;
    qs = (inst == 0) ? q0.size() : q1.size();
    if (qs == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_strobe inst%0d got=strobe want=none", inst);
      return;
    end
    if (inst == 0) e = q0.pop_front();
    else           e = q1.pop_front();
    checkOutput($sformatf("byte_out inst%0d", inst), rdByte(inst), 32'(e.b));
    checkOutput($sformatf("lane_idx inst%0d", inst), rdLane(inst), 32'(e.lane));
    checkOutput($sformatf("overrun inst%0d", inst), rdOvr(inst), 32'(e.ovr));
  endtask

  always @(negedge clk) begin
    if (bs0) monCheck(0);
    if (bs1) monCheck(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int inst, input exp_t e);
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic doReset(input int inst);
    cpu_n[inst]   = 1'b1;
    ras_n[inst]   = 1'b1;
    cas_n[inst]   = 1'b1;
    reset_n[inst] = 1'b0;
    tick();
    reset_n[inst] = 1'b1;
    npush[inst]   = 0;
    ovr_m[inst]   = 1'b0;
    @(negedge clk);
    checkOutput("reset byte_out", rdByte(inst), 0);
    checkOutput("reset strobe", rdStrobe(inst), 0);
    checkOutput("reset lane_idx", rdLane(inst), 0);
    checkOutput("reset overrun", rdOvr(inst), 0);
  endtask

  // One video slot of npulses CAS strobes followed by a CPU slot; with collide set,
  // cpu_n drops on the same clock as the final CAS rising edge.
  task automatic applyStimulus(input int inst, input logic [31:0] word, input int npulses,
                               input logic de_v, input logic sen, input logic [1:0] amt,
                               input bit collide);
    int lanes;
    int k;
    lanes           = lanes_p[inst];
    k               = sen ? ((int'(amt) > smax_p[inst]) ? smax_p[inst] : int'(amt)) : 0;
    de[inst]        = de_v;
    shift_en[inst]  = sen;
    shift_amt[inst] = amt;
    if (inst == 0) din0 = word[15:0];
    else           din1 = word;
    cpu_n[inst] = 1'b1;
    ras_n[inst] = 1'b0;
    cas_n[inst] = 1'b1;
    tick();
    for (int n = 0; n < npulses; n++) begin
      int         lane;
      logic [7:0] sel;
      logic [7:0] outb;
      bit         hit;
      lane = (n < lanes) ? n : lanes - 1;
      sel  = laneByte(inst, word, lane);
      outb = (k == 0) ? sel : pastByte(inst, k);
      hit  = collide && (n == npulses - 1);
      cas_n[inst] = 1'b0;
      tick();
      tick();
      cas_n[inst] = 1'b1;
      if (hit) cpu_n[inst] = 1'b0;
      if (!hit && n < lanes) begin
        stream[inst][npush[inst]] = de_v ? sel : 8'h00;
        npush[inst]++;
        pushExp(inst, '{outb, (n + 1 < lanes) ? n + 1 : lanes - 1, ovr_m[inst]});
      end else if (!hit) begin
        ovr_m[inst] = 1'b1;
      end
      tick();
      @(negedge clk);
      if (hit) begin
        checkOutput("collide strobe", rdStrobe(inst), 0);
        checkOutput("collide lane_idx", rdLane(inst), 0);
      end else if (n >= lanes) begin
        checkOutput("overrun set", rdOvr(inst), 1);
        checkOutput("overrun lane_idx", rdLane(inst), 32'(lanes - 1));
      end
      tick();
    end
    ras_n[inst] = 1'b1;
    cas_n[inst] = 1'b1;
    cpu_n[inst] = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("cpu_slot lane_idx", rdLane(inst), 0);
    checkOutput("cpu_slot strobe", rdStrobe(inst), 0);
    tick();
  endtask

  task automatic randomSlot(input int inst);
    applyStimulus(inst, $urandom, lanes_p[inst], 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic runInstance(input int inst);
    int lanes;
    lanes = lanes_p[inst];
    doReset(inst);
    if (inst == 0) begin
      applyStimulus(0, 32'h0000A55A, 2, 1'b1, 1'b0, 2'd0, 1'b0);
      applyStimulus(0, 32'h00002211, 2, 1'b0, 1'b1, 2'd1, 1'b0);
      applyStimulus(0, 32'h00004433, 2, 1'b1, 1'b1, 2'd1, 1'b0);
    end else begin
      applyStimulus(1, 32'h04030201, 4, 1'b1, 1'b1, 2'd3, 1'b0);
      applyStimulus(1, 32'h08070605, 4, 1'b1, 1'b1, 2'd3, 1'b0);
    end
    repeat (10) randomSlot(inst);
    applyStimulus(inst, $urandom, $urandom_range(1, lanes), 1'b1, 1'b1,
                  2'(smax_p[inst]), 1'b1);
    applyStimulus(inst, $urandom, lanes, 1'b1, 1'b1, 2'd1, 1'b0);
    repeat (4) randomSlot(inst);
    applyStimulus(inst, $urandom, lanes + 1, 1'b1, 1'b0, 2'd0, 1'b0);
    randomSlot(inst);
    doReset(inst);
    applyStimulus(inst, $urandom, lanes, 1'b1, 1'b1, 2'd3, 1'b0);
    randomSlot(inst);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset_n[i]   = 1'b0;
      cpu_n[i]     = 1'b1;
      ras_n[i]     = 1'b1;
      cas_n[i]     = 1'b1;
      de[i]        = 1'b0;
      shift_en[i]  = 1'b0;
      shift_amt[i] = 2'd0;
      npush[i]     = 0;
      ovr_m[i]     = 1'b0;
    end
    din0 = '0;
    din1 = '0;
    repeat (2) tick();
    runInstance(0);
    runInstance(1);
    repeat (4) tick();
    checkOutput("drained inst0", 32'(q0.size()), 0);
    checkOutput("drained inst1", 32'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
